ram_be_init: RTL and testbench
==============================

// Module: ram_be_init
// PURPOSE
//  Synchronous simple dual-port RAM (one read port, one write port), successor to the basic data RAM.
//  Adds per-byte write enables, read enable with a valid flag, selectable read-during-write mode,
//  an optional output pipeline stage, and a post-reset clear sequencer.
//  Used as data/scratch memory behind bus slaves and as buffer storage for FIFOs/caches.
// PARAMETERS
//  DATA_WIDTH      32  word width in bits; must be a multiple of 8; NB = DATA_WIDTH/8 byte lanes
//  ADDR_WIDTH      8   address width; RAM_DEPTH = 1 << ADDR_WIDTH words
//  OUT_REG         0   0: read latency 1 cycle; 1: extra output register, latency 2 cycles
//  WRITE_FIRST     0   0: same-address read/write returns old word; 1: returns newly written bytes
//  CLEAR_ON_RESET  1   1: after reset, write INIT_VALUE to every word before ready; 0: no clear
//  INIT_VALUE      0   DATA_WIDTH-bit word written by the clear sequencer
// PORTS
//  clk            in   1           clock, all activity on rising edge
//  rst            in   1           asynchronous, active-high reset
//  ready          out  1           1 = RAM accepts reads/writes; 0 during reset and clear
//  re             in   1           read enable, sampled at clk when ready=1
//  read_address   in   ADDR_WIDTH  read word address
//  data_o         out  DATA_WIDTH  read data; holds last value when no read completes
//  data_valid     out  1           1-cycle pulse: data_o carries the word for an accepted read
//  we             in   1           write enable, sampled at clk when ready=1
//  byte_en        in   NB          per-lane write mask; bit i covers data_i[8i+7:8i]
//  write_address  in   ADDR_WIDTH  write word address
//  data_i         in   DATA_WIDTH  write data
// BEHAVIOUR
//  Reset (rst=1, async): ready=0, data_o=0, data_valid=0, pipeline valid bits=0, clear counter=0,
//   state=INIT (CLEAR_ON_RESET=1) or READY-pending. Memory array contents are not reset directly.
//  State machine: INIT -> READY.
//   INIT: each clk writes INIT_VALUE (all lanes) to address clr_cnt, clr_cnt++. After writing
//    RAM_DEPTH-1, go READY; ready=1 from the following cycle. Clear takes exactly RAM_DEPTH cycles
//    after rst deasserts. re/we ignored in INIT; data_valid stays 0.
//   CLEAR_ON_RESET=0: ready=1 at the first clk edge after rst deasserts; no clear writes.
//   rst asserted mid-clear: sequencer restarts at address 0 on release.
//  Write: at clk with ready=1, we=1: lanes with byte_en[i]=1 take data_i; others unchanged.
//   we=1 with byte_en=0 is a legal no-op.
//  Read: at clk with ready=1, re=1: word at read_address captured.
//   OUT_REG=0: data_o and data_valid=1 after edge N+1 (1-cycle latency).
//   OUT_REG=1: data_o and data_valid=1 after edge N+2; back-to-back reads give 1 word/cycle.
//   re=0: no memory read; data_o holds; data_valid=0.
//  Collision (re, we, same address, same cycle):
//   WRITE_FIRST=0: data_o = word before the write.
//   WRITE_FIRST=1: data_o lanes with byte_en=1 = data_i, other lanes = old word (bypass merge).
//   Different addresses: fully independent.
//  Reads issued in the last INIT cycle are dropped; first accepted read is the cycle ready=1.
//  Address arithmetic: clr_cnt is ADDR_WIDTH+1 bits; terminal count detected at RAM_DEPTH-1; no wrap.
// TESTING
//  Clear: DEPTH=16, INIT_VALUE=32'hDEAD_BEEF, release rst -> ready rises after 16 cycles; all reads = DEADBEEF.
//  Byte enables: write 32'h11223344 be=4'hF to addr 5, then 32'hAABBCCDD be=4'b0101 -> read 5 = 32'h11BB33DD.
//  Latency: OUT_REG=0/1, re at cycle N addr 5 -> data_valid and data at N+1 / N+2; re=0 -> data_o held.
//  Collision: old word 0, write 32'hCAFEF00D be=4'hF while reading same addr -> WRITE_FIRST=0 gives 0, =1 gives CAFEF00D.
//  Reset mid-clear: assert rst at clr_cnt=7, release -> ready low, clear restarts at 0, full DEPTH cycles.
//  Gating: we/re pulsed during INIT -> no memory change beyond clear, data_valid never asserted.

Source files
------------

// File: rtl/ram_be_init.sv
// Simple dual-port RAM with byte-lane writes, selectable read-during-write and a post-reset clear sequencer.
// Latency: read data 1 cycle after an accepted read (2 with OUT_REG=1); clear takes RAM_DEPTH cycles.
// Backpressure: none; ready=0 during reset/clear, and re/we are ignored while ready=0.
module ram_be_init #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int OUT_REG        = 0,
    parameter int WRITE_FIRST    = 0,
    parameter int CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    ready,
    input  logic                    re,
    input  logic [ADDR_WIDTH-1:0]   read_address,
    output logic [DATA_WIDTH-1:0]   data_o,
    output logic                    data_valid,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] byte_en,
    input  logic [ADDR_WIDTH-1:0]   write_address,
    input  logic [DATA_WIDTH-1:0]   data_i
);

    localparam int NB        = DATA_WIDTH / 8;
    localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CLR_LAST = (ADDR_WIDTH + 1)'(RAM_DEPTH - 1);

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_WAIT  = 2'd1,
        S_READY = 2'd2
    } state_t;

    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_WAIT;

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   clr_cnt;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] dat1;
    logic                  vld1;
    logic                  rd_acc;

    assign ready  = (state_q == S_READY);
    assign rd_acc = ready && re;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RST_STATE;
            clr_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_CLEAR)
                clr_cnt <= clr_cnt + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CLEAR: if (clr_cnt == CLR_LAST) state_d = S_READY;
            S_WAIT:  state_d = S_READY;
            default: state_d = S_READY;
        endcase
    end

    // Clear writes own the array until ready; user writes are masked per lane.
    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR) begin
            mem[clr_cnt[ADDR_WIDTH-1:0]] <= INIT_VALUE;
        end else if (ready && we) begin
            for (int i = 0; i < NB; i++)
                if (byte_en[i])
                    mem[write_address][8*i +: 8] <= data_i[8*i +: 8];
        end
    end

    // Write-first mode merges the incoming lanes over the stored word on an address match.
    always_comb begin
        rd_word = mem[read_address];
        if (WRITE_FIRST != 0 && we && (write_address == read_address)) begin
            for (int i = 0; i < NB; i++)
                if (byte_en[i])
                    rd_word[8*i +: 8] = data_i[8*i +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dat1 <= '0;
            vld1 <= 1'b0;
        end else begin
            vld1 <= rd_acc;
            if (rd_acc)
                dat1 <= rd_word;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DATA_WIDTH-1:0] dat2;
            logic                  vld2;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dat2 <= '0;
                    vld2 <= 1'b0;
                end else begin
                    vld2 <= vld1;
                    if (vld1)
                        dat2 <= dat1;
                end
            end
            assign data_o     = dat2;
            assign data_valid = vld2;
        end else begin : g_noreg
            assign data_o     = dat1;
            assign data_valid = vld1;
        end
    endgenerate

endmodule

// File: tb/tb_ram_be_init.sv
// Directed bench for ram_be_init: three instances (1-cycle read-first, 2-cycle write-first, no clear)
// share one stimulus stream; vector table plus hand sequences for clear, gating and reset mid-clear.
module tb_ram_be_init;

    logic        clk;
    logic        rst;
    logic        re, we;
    logic [3:0]  be, ra, wa;
    logic [31:0] din;
    logic        ready0, ready1, ready2;
    logic [31:0] data0, data1, data2;
    logic        dv0, dv1, dv2;

    int n_chk = 0;
    int n_err = 0;

    ram_be_init #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .OUT_REG(0), .WRITE_FIRST(0),
                  .CLEAR_ON_RESET(1), .INIT_VALUE(32'hDEAD_BEEF)) u0 (
        .clk(clk), .rst(rst), .ready(ready0), .re(re), .read_address(ra),
        .data_o(data0), .data_valid(dv0), .we(we), .byte_en(be),
        .write_address(wa), .data_i(din));

    ram_be_init #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .OUT_REG(1), .WRITE_FIRST(1),
                  .CLEAR_ON_RESET(1), .INIT_VALUE(32'hDEAD_BEEF)) u1 (
        .clk(clk), .rst(rst), .ready(ready1), .re(re), .read_address(ra),
        .data_o(data1), .data_valid(dv1), .we(we), .byte_en(be),
        .write_address(wa), .data_i(din));

    ram_be_init #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .OUT_REG(0), .WRITE_FIRST(0),
                  .CLEAR_ON_RESET(0), .INIT_VALUE(32'hDEAD_BEEF)) u2 (
        .clk(clk), .rst(rst), .ready(ready2), .re(re), .read_address(ra),
        .data_o(data2), .data_valid(dv2), .we(we), .byte_en(be),
        .write_address(wa), .data_i(din));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        re;
        logic        we;
        logic [3:0]  be;
        logic [3:0]  ra;
        logic [3:0]  wa;
        logic [31:0] din;
        logic        v;
        logic [31:0] d0;
        logic [31:0] d1;
    } vec_t;

    vec_t tbl [14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        int rise;
        int dv_init;

        //            re  we  be     ra  wa  din           v  d0 (u0)       d1 (u1)
        tbl[0]  = '{1'b0, 1'b1, 4'hF, 4'd0, 4'd5, 32'h11223344, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[1]  = '{1'b0, 1'b1, 4'h5, 4'd0, 4'd5, 32'hAABBCCDD, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[2]  = '{1'b1, 1'b0, 4'h0, 4'd5, 4'd0, 32'h00000000, 1'b1, 32'h11BB33DD, 32'h11BB33DD};
        tbl[3]  = '{1'b0, 1'b0, 4'h0, 4'd5, 4'd0, 32'h00000000, 1'b0, 32'h11BB33DD, 32'h11BB33DD};
        tbl[4]  = '{1'b1, 1'b1, 4'h0, 4'd5, 4'd5, 32'hFFFFFFFF, 1'b1, 32'h11BB33DD, 32'h11BB33DD};
        tbl[5]  = '{1'b0, 1'b1, 4'hF, 4'd0, 4'd7, 32'h00000000, 1'b0, 32'h11BB33DD, 32'h11BB33DD};
        tbl[6]  = '{1'b1, 1'b1, 4'hF, 4'd7, 4'd7, 32'hCAFEF00D, 1'b1, 32'h00000000, 32'hCAFEF00D};
        tbl[7]  = '{1'b1, 1'b0, 4'h0, 4'd7, 4'd0, 32'h00000000, 1'b1, 32'hCAFEF00D, 32'hCAFEF00D};
        tbl[8]  = '{1'b1, 1'b1, 4'hA, 4'd7, 4'd7, 32'h12345678, 1'b1, 32'hCAFEF00D, 32'h12FE560D};
        tbl[9]  = '{1'b1, 1'b0, 4'h0, 4'd7, 4'd0, 32'h00000000, 1'b1, 32'h12FE560D, 32'h12FE560D};
        tbl[10] = '{1'b1, 1'b1, 4'hF, 4'd5, 4'd9, 32'h0BADC0DE, 1'b1, 32'h11BB33DD, 32'h11BB33DD};
        tbl[11] = '{1'b1, 1'b0, 4'h0, 4'd9, 4'd0, 32'h00000000, 1'b1, 32'h0BADC0DE, 32'h0BADC0DE};
        tbl[12] = '{1'b1, 1'b1, 4'h2, 4'd0, 4'd0, 32'h0000AB00, 1'b1, 32'hDEADBEEF, 32'hDEADABEF};
        tbl[13] = '{1'b1, 1'b0, 4'h0, 4'd0, 4'd0, 32'h00000000, 1'b1, 32'hDEADABEF, 32'hDEADABEF};

        rst = 1'b1; re = 1'b0; we = 1'b0; be = '0; ra = '0; wa = '0; din = '0;
        tick();
        tick();
        chk("rst_ready0", {31'b0, ready0}, 32'd0);
        chk("rst_ready1", {31'b0, ready1}, 32'd0);
        chk("rst_ready2", {31'b0, ready2}, 32'd0);
        chk("rst_data0", data0, 32'd0);
        chk("rst_dv0", {31'b0, dv0}, 32'd0);
        chk("rst_data1", data1, 32'd0);
        chk("rst_dv1", {31'b0, dv1}, 32'd0);

        // Release reset with read and write held high through the whole clear.
        we = 1'b1; be = 4'hF; wa = 4'd3; din = 32'h12345678; re = 1'b1; ra = 4'd3;
        rst = 1'b0;
        rise = 0;
        dv_init = 0;
        for (int c = 1; c <= 20 && rise == 0; c++) begin
            tick();
            if (c == 1) chk("noclear_ready_after_1", {31'b0, ready2}, 32'd1);
            if (dv0 || dv1) dv_init++;
            if (ready0) rise = c;
        end
        we = 1'b0; re = 1'b0;
        chk("clear_cycles", rise, 32'd16);
        chk("init_dv_pulses", dv_init, 32'd0);
        chk("clear_ready1", {31'b0, ready1}, 32'd1);
        tick();
        chk("last_init_read_dropped_u1", {31'b0, dv1}, 32'd0);
        chk("idle_dv0", {31'b0, dv0}, 32'd0);

        // Back-to-back readout of the whole array; u1 trails u0 by one cycle.
        for (int a = 0; a <= 16; a++) begin
            re = (a < 16);
            ra = a[3:0];
            tick();
            if (a < 16) begin
                chk($sformatf("clr_dv0_a%0d", a), {31'b0, dv0}, 32'd1);
                chk($sformatf("clr_data0_a%0d", a), data0, 32'hDEADBEEF);
            end else begin
                chk("clr_dv0_end", {31'b0, dv0}, 32'd0);
            end
            if (a >= 1) begin
                chk($sformatf("clr_dv1_a%0d", a - 1), {31'b0, dv1}, 32'd1);
                chk($sformatf("clr_data1_a%0d", a - 1), data1, 32'hDEADBEEF);
            end else begin
                chk("clr_dv1_first", {31'b0, dv1}, 32'd0);
            end
        end
        re = 1'b0;
        tick();

        for (int i = 0; i < 14; i++) begin
            re = tbl[i].re; we = tbl[i].we; be = tbl[i].be;
            ra = tbl[i].ra; wa = tbl[i].wa; din = tbl[i].din;
            tick();
            chk($sformatf("v%0d_data0", i), data0, tbl[i].d0);
            chk($sformatf("v%0d_dv0", i), {31'b0, dv0}, {31'b0, tbl[i].v});
            chk($sformatf("v%0d_dv1_early", i), {31'b0, dv1}, 32'd0);
            re = 1'b0; we = 1'b0;
            tick();
            chk($sformatf("v%0d_data1", i), data1, tbl[i].d1);
            chk($sformatf("v%0d_dv1", i), {31'b0, dv1}, {31'b0, tbl[i].v});
            chk($sformatf("v%0d_hold0", i), data0, tbl[i].d0);
            chk($sformatf("v%0d_dv0_idle", i), {31'b0, dv0}, 32'd0);
        end

        // Reset in the middle of a clear, then let a full clear complete.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 1; c <= 7; c++) tick();
        rst = 1'b1;
        #1;
        chk("midclr_ready0", {31'b0, ready0}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        rise = 0;
        for (int c = 1; c <= 20 && rise == 0; c++) begin
            tick();
            if (ready0) rise = c;
        end
        chk("midclr_clear_cycles", rise, 32'd16);
        re = 1'b1; ra = 4'd9;
        tick();
        chk("midclr_a9_u0", data0, 32'hDEADBEEF);
        ra = 4'd7;
        tick();
        chk("midclr_a7_u0", data0, 32'hDEADBEEF);
        chk("midclr_a9_u1", data1, 32'hDEADBEEF);
        re = 1'b0;
        tick();
        chk("midclr_a7_u1", data1, 32'hDEADBEEF);
        chk("midclr_dv1", {31'b0, dv1}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
